multi_pulse_generator: RTL and testbench
========================================

Name: multi_pulse_generator

Overview:
Next-generation pulse generator: NUM_CH_P independent channels, each producing a train of pulses with run-time delay, width, gap and repeat count. A shared post-reset ready delay gates all channels. It sits where pulse_generator sits today and adds multi-channel, repeat/continuous and abort support.

Parameters:
NUM_CH_P, 4, number of independent pulse channels (1..16)
CNT_W_P, 16, width of every timing/count config field
READY_DELAY_P, reset_delay_c, clk cycles from reset release to ready

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous assert, active-low; clears all state
start  in  NUM_CH_P  per-channel start, level sampled each edge
stop  in  NUM_CH_P  per-channel abort
delay_cfg  in  NUM_CH_P*CNT_W_P  per-channel start delay D, ch0 in LSBs
width_cfg  in  NUM_CH_P*CNT_W_P  per-channel pulse width W
gap_cfg  in  NUM_CH_P*CNT_W_P  per-channel low time between pulses G
repeat_cfg  in  NUM_CH_P*CNT_W_P  per-channel pulse count R; 0 = continuous
ready  out  1  high once the post-reset delay has expired
pulse_out  out  NUM_CH_P  registered pulse outputs
busy  out  NUM_CH_P  channel not IDLE
done  out  NUM_CH_P  1-cycle strobe, train completed normally
cfg_err  out  NUM_CH_P  1-cycle strobe, start rejected (W==0)

Behaviour:
- Reset (reset_n low, async): ready, pulse_out, busy, done and cfg_err = 0; all channels IDLE; counters cleared.
- Ready: counter starts at first edge after reset_n high. ready rises exactly READY_DELAY_P cycles after release, then stays high. Starts while ready=0 are ignored, with no error.
- Per-channel FSM states: IDLE, DELAY, ACTIVE, GAP. All outputs are registered.
- IDLE, start=1, ready=1, stop=0 at edge N: latch D/W/G/R for this channel (config is ignored at all other times).
  - W==0: cfg_err=1 for one cycle; stay IDLE.
  - D==0: go to ACTIVE; pulse_out rises at edge N+1.
  - D>0: go to DELAY; pulse_out rises at edge N+D.
- busy rises at edge N in every accepted case.
- ACTIVE: pulse_out high for exactly W cycles, then:
  - If pulses remain (or R==0): go to GAP.
  - Otherwise: go to IDLE and assert done for one cycle, coincident with the pulse_out falling edge. busy falls at the same edge.
- GAP: pulse_out low for max(G,1) cycles (G==0 treated as 1), then ACTIVE.
- Pulse counting: R pulses total. R==1 gives a single pulse. R==0 repeats until stop and never asserts done.
- start while busy is ignored (no retrigger, no error).
- stop=1 in any non-IDLE state: next edge goes to IDLE with pulse_out=0, busy=0, no done. stop and start in the same cycle while IDLE: stop wins, not started.
- Channels are fully independent; simultaneous starts on any channel subset are all accepted.
- Counters: one CNT_W_P-bit down-counter for the phase and one CNT_W_P-bit pulse counter per channel. No wrap: max D/W/G = 2^CNT_W_P-1 cycles.

Decomposition:
- Package pulse_generator_pkg: add pg_state_t enum (IDLE, DELAY, ACTIVE, GAP), cnt_w_c default, and ready delay default reusing reset_delay_c.
- Sub-module pulse_gen_channel: one FSM plus counters for a single channel, taking the ready input. The top level holds the ready counter, a generate loop over channels, and config bus slicing.

Test Plan:
- Ready: reset_n low 100ns, release with READY_DELAY_P=5, clk 10ns → ready rises 50ns after release; start asserted at 20ns produces no pulse.
- Single pulse, ch0: D=3, W=4, R=1, start at edge N → pulse_out high edges N+3..N+7, done at N+7, busy N..N+7.
- Train, ch1: D=0, W=2, G=3, R=3 → pulses at N+1, N+6, N+11, each 2 cycles; one done at N+13; ch0/2/3 quiet.
- Continuous + stop, ch2: R=0, W=1, G=0 → 1-high/1-low toggle; stop at arbitrary cycle → pulse_out 0 and busy 0 next edge, no done.
- Errors/corners: W=0 start → cfg_err one cycle, busy stays 0; start while busy ignored; start+stop same cycle from IDLE → no start.
- Reset mid-pulse: reset_n low during ACTIVE → pulse_out and ready drop immediately (asynchronously); after release, ready re-delays READY_DELAY_P cycles.

Source files
------------

// File: rtl/pulse_generator_pkg.sv
// Shared types and defaults for the multi-channel pulse generator.
package pulse_generator_pkg;

    localparam int reset_delay_c = 5;
    localparam int cnt_w_c       = 16;
    localparam int ready_delay_c = reset_delay_c;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        ACTIVE = 2'd2,
        GAP    = 2'd3
    } pg_state_t;

endpackage

// File: rtl/pulse_gen_channel.sv
// One pulse-train channel: start delay, then repeated high/low phases with optional repeat count.
module pulse_gen_channel
    import pulse_generator_pkg::*;
#(
    parameter int CNT_W_P = cnt_w_c
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ready,
    input  logic               start,
    input  logic               stop,
    input  logic [CNT_W_P-1:0] delay_cfg,
    input  logic [CNT_W_P-1:0] width_cfg,
    input  logic [CNT_W_P-1:0] gap_cfg,
    input  logic [CNT_W_P-1:0] repeat_cfg,
    output logic               pulse_out,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    localparam logic [CNT_W_P-1:0] one_c = CNT_W_P'(1);

    pg_state_t          state_q;
    logic [CNT_W_P-1:0] phase_q;
    logic [CNT_W_P-1:0] rem_q;
    logic [CNT_W_P-1:0] width_q;
    logic [CNT_W_P-1:0] gap_q;
    logic               pulse_q;
    logic               busy_q;
    logic               done_q;
    logic               cfg_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            rem_q     <= '0;
            width_q   <= '0;
            gap_q     <= '0;
            pulse_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            if (state_q == IDLE) begin
                if (start && ready && !stop) begin
                    if (width_cfg == '0) begin
                        cfg_err_q <= 1'b1;
                    end else begin
                        // Zero delay shares the DELAY path with a zero countdown, so the
                        // first pulse still rises one edge after acceptance.
                        width_q <= width_cfg;
                        gap_q   <= gap_cfg;
                        rem_q   <= repeat_cfg;
                        phase_q <= (delay_cfg == '0) ? '0 : delay_cfg - one_c;
                        busy_q  <= 1'b1;
                        state_q <= DELAY;
                    end
                end
            end else if (stop) begin
                state_q <= IDLE;
                pulse_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    DELAY, GAP: begin
                        if (phase_q == '0) begin
                            state_q <= ACTIVE;
                            pulse_q <= 1'b1;
                            phase_q <= width_q - one_c;
                        end else begin
                            phase_q <= phase_q - one_c;
                        end
                    end
                    ACTIVE: begin
                        if (phase_q == '0) begin
                            pulse_q <= 1'b0;
                            // rem_q of zero means continuous and is never decremented
                            if (rem_q == one_c) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                if (rem_q != '0) rem_q <= rem_q - one_c;
                                state_q <= GAP;
                                phase_q <= (gap_q == '0) ? '0 : gap_q - one_c;
                            end
                        end else begin
                            phase_q <= phase_q - one_c;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign pulse_out = pulse_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: rtl/multi_pulse_generator.sv
// Multi-channel pulse generator: shared post-reset ready delay gating independent pulse-train channels.
module multi_pulse_generator
    import pulse_generator_pkg::*;
#(
    parameter int NUM_CH_P      = 4,
    parameter int CNT_W_P       = cnt_w_c,
    parameter int READY_DELAY_P = ready_delay_c
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_CH_P-1:0]          start,
    input  logic [NUM_CH_P-1:0]          stop,
    input  logic [NUM_CH_P*CNT_W_P-1:0]  delay_cfg,
    input  logic [NUM_CH_P*CNT_W_P-1:0]  width_cfg,
    input  logic [NUM_CH_P*CNT_W_P-1:0]  gap_cfg,
    input  logic [NUM_CH_P*CNT_W_P-1:0]  repeat_cfg,
    output logic                         ready,
    output logic [NUM_CH_P-1:0]          pulse_out,
    output logic [NUM_CH_P-1:0]          busy,
    output logic [NUM_CH_P-1:0]          done,
    output logic [NUM_CH_P-1:0]          cfg_err
);

    localparam int              RDY_W      = (READY_DELAY_P > 1) ? $clog2(READY_DELAY_P) : 1;
    localparam logic [RDY_W-1:0] rdy_last_c = RDY_W'((READY_DELAY_P > 0) ? READY_DELAY_P - 1 : 0);
    localparam logic [RDY_W-1:0] rdy_one_c  = RDY_W'(1);

    logic [RDY_W-1:0] rdy_cnt_q, rdy_cnt_d;
    logic             ready_q, ready_d;

    // Counts edges after release; ready latches high on the READY_DELAY_P-th edge.
    always_comb begin
        rdy_cnt_d = rdy_cnt_q;
        ready_d   = ready_q;
        if (!ready_q) begin
            if (rdy_cnt_q == rdy_last_c) ready_d   = 1'b1;
            else                         rdy_cnt_d = rdy_cnt_q + rdy_one_c;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            rdy_cnt_q <= rdy_cnt_d;
            ready_q   <= ready_d;
        end
    end

    assign ready = ready_q;

    for (genvar i = 0; i < NUM_CH_P; i++) begin : g_ch
        pulse_gen_channel #(
            .CNT_W_P(CNT_W_P)
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .ready     (ready_q),
            .start     (start[i]),
            .stop      (stop[i]),
            .delay_cfg (delay_cfg[i*CNT_W_P +: CNT_W_P]),
            .width_cfg (width_cfg[i*CNT_W_P +: CNT_W_P]),
            .gap_cfg   (gap_cfg[i*CNT_W_P +: CNT_W_P]),
            .repeat_cfg(repeat_cfg[i*CNT_W_P +: CNT_W_P]),
            .pulse_out (pulse_out[i]),
            .busy      (busy[i]),
            .done      (done[i]),
            .cfg_err   (cfg_err[i])
        );
    end

endmodule

// File: tb/tb_multi_pulse_generator.sv
// Scoreboard bench: a timeline model predicts pulse edges, done and cfg_err events per channel.
module tb_multi_pulse_generator;

    localparam int NCH     = 4;
    localparam int CW      = 16;
    localparam int RD      = 5;
    localparam int HORIZON = 3000;
    localparam int NEVER   = 32'h7fffffff;
    localparam int K_RISE  = 0;
    localparam int K_FALL  = 1;
    localparam int K_DONE  = 2;
    localparam int K_ERR   = 3;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [NCH-1:0]      start = '0;
    logic [NCH-1:0]      stop = '0;
    logic [NCH*CW-1:0]   delay_cfg = '0;
    logic [NCH*CW-1:0]   width_cfg = '0;
    logic [NCH*CW-1:0]   gap_cfg = '0;
    logic [NCH*CW-1:0]   repeat_cfg = '0;
    logic                ready;
    logic [NCH-1:0]      pulse_out;
    logic [NCH-1:0]      busy;
    logic [NCH-1:0]      done;
    logic [NCH-1:0]      cfg_err;

    multi_pulse_generator #(
        .NUM_CH_P(NCH),
        .CNT_W_P(CW),
        .READY_DELAY_P(RD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .delay_cfg(delay_cfg), .width_cfg(width_cfg), .gap_cfg(gap_cfg), .repeat_cfg(repeat_cfg),
        .ready(ready), .pulse_out(pulse_out), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int rel_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rel_cnt <= 0;
        else          rel_cnt <= rel_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    ev_t exp_q[NCH][$];
    int  cfg_d[NCH], cfg_w[NCH], cfg_g[NCH], cfg_r[NCH];
    int  b_start[NCH], b_end[NCH];
    int  t_r0[NCH], t_w[NCH], t_per[NCH], t_rep[NCH];
    logic [NCH-1:0] prev_pulse = '0;

    function automatic string kname(input int k);
        case (k)
            K_RISE: return "rise";
            K_FALL: return "fall";
            K_DONE: return "done";
            default: return "cfg_err";
        endcase
    endfunction

    function automatic void push_ev(input int ch, input int c, input int k);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        exp_q[ch].push_back(e);
    endfunction

    // Expected pulse level of a channel's current train after edge t.
    function automatic bit level_at(input int ch, input int t);
        int rel;
        rel = t - t_r0[ch];
        if (rel < 0) return 1'b0;
        if (t_rep[ch] != 0 && rel / t_per[ch] >= t_rep[ch]) return 1'b0;
        return (rel % t_per[ch]) < t_w[ch];
    endfunction

    task automatic model_edge(input logic [NCH-1:0] st, input logic [NCH-1:0] sp);
        int n;
        bit rdy;
        n   = cyc + 1;
        rdy = reset_n && (rel_cnt >= RD);
        for (int ch = 0; ch < NCH; ch++) begin
            if (cyc >= b_end[ch]) begin
                if (st[ch] && !sp[ch] && rdy) begin
                    if (cfg_w[ch] == 0) begin
                        push_ev(ch, n, K_ERR);
                    end else begin
                        t_r0[ch]    = n + ((cfg_d[ch] == 0) ? 1 : cfg_d[ch]);
                        t_w[ch]     = cfg_w[ch];
                        t_per[ch]   = cfg_w[ch] + ((cfg_g[ch] == 0) ? 1 : cfg_g[ch]);
                        t_rep[ch]   = cfg_r[ch];
                        b_start[ch] = n;
                        if (cfg_r[ch] == 0) begin
                            for (int k = 0; t_r0[ch] + k * t_per[ch] <= n + HORIZON; k++) begin
                                push_ev(ch, t_r0[ch] + k * t_per[ch], K_RISE);
                                push_ev(ch, t_r0[ch] + k * t_per[ch] + t_w[ch], K_FALL);
                            end
                            b_end[ch] = NEVER;
                        end else begin
                            for (int k = 0; k < cfg_r[ch]; k++) begin
                                push_ev(ch, t_r0[ch] + k * t_per[ch], K_RISE);
                                push_ev(ch, t_r0[ch] + k * t_per[ch] + t_w[ch], K_FALL);
                            end
                            b_end[ch] = t_r0[ch] + (cfg_r[ch] - 1) * t_per[ch] + t_w[ch];
                            push_ev(ch, b_end[ch], K_DONE);
                        end
                    end
                end
            end else if (sp[ch]) begin
                while (exp_q[ch].size() > 0 && exp_q[ch][exp_q[ch].size()-1].cyc >= n)
                    void'(exp_q[ch].pop_back());
                if (level_at(ch, n - 1)) push_ev(ch, n, K_FALL);
                b_end[ch] = n;
            end
        end
    endtask

    task automatic tick(input logic [NCH-1:0] st, input logic [NCH-1:0] sp);
        @(negedge clk);
        model_edge(st, sp);
        start = st;
        stop  = sp;
        for (int ch = 0; ch < NCH; ch++) begin
            delay_cfg[ch*CW +: CW]  = CW'(cfg_d[ch]);
            width_cfg[ch*CW +: CW]  = CW'(cfg_w[ch]);
            gap_cfg[ch*CW +: CW]    = CW'(cfg_g[ch]);
            repeat_cfg[ch*CW +: CW] = CW'(cfg_r[ch]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick('0, '0);
    endtask

    task automatic set_cfg(input int ch, input int d, input int w, input int g, input int r);
        cfg_d[ch] = d; cfg_w[ch] = w; cfg_g[ch] = g; cfg_r[ch] = r;
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic expect_ev(input int ch, input int k);
        checks++;
        if (exp_q[ch].size() > 0 && exp_q[ch][0].cyc == cyc && exp_q[ch][0].kind == k) begin
            void'(exp_q[ch].pop_front());
        end else begin
            errors++;
            if (exp_q[ch].size() > 0)
                $display("FAIL event ch%0d: observed %s at cycle %0d, expected %s at cycle %0d",
                         ch, kname(k), cyc, kname(exp_q[ch][0].kind), exp_q[ch][0].cyc);
            else
                $display("FAIL event ch%0d: observed %s at cycle %0d, expected nothing", ch, kname(k), cyc);
            if (exp_q[ch].size() > 0 && exp_q[ch][0].cyc == cyc) void'(exp_q[ch].pop_front());
        end
    endtask

    task automatic monitor_step();
        if (!reset_n) begin
            prev_pulse = pulse_out;
            return;
        end
        check_bit("ready", ready, rel_cnt >= RD);
        for (int ch = 0; ch < NCH; ch++) begin
            while (exp_q[ch].size() > 0 && exp_q[ch][0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL event ch%0d: missing %s, got nothing at cycle %0d, expected it",
                         ch, kname(exp_q[ch][0].kind), exp_q[ch][0].cyc);
                void'(exp_q[ch].pop_front());
            end
            if (pulse_out[ch] !== prev_pulse[ch]) expect_ev(ch, pulse_out[ch] ? K_RISE : K_FALL);
            if (done[ch] !== 1'b0)    expect_ev(ch, K_DONE);
            if (cfg_err[ch] !== 1'b0) expect_ev(ch, K_ERR);
            check_bit($sformatf("busy ch%0d cyc%0d", ch, cyc), busy[ch],
                      (b_start[ch] <= cyc) && (cyc < b_end[ch]));
        end
        prev_pulse = pulse_out;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            monitor_step();
        end
    end

    initial begin
        logic [NCH-1:0] st, sp;
        for (int ch = 0; ch < NCH; ch++) begin
            set_cfg(ch, 0, 1, 0, 1);
            b_start[ch] = 0;
            b_end[ch]   = 0;
        end

        // Reset state, and starts held through reset and the ready delay are ignored
        @(negedge clk);
        check_bit("reset ready", ready, 1'b0);
        check_bit("reset pulse_out", |pulse_out, 1'b0);
        check_bit("reset busy", |busy, 1'b0);
        check_bit("reset done", |done, 1'b0);
        check_bit("reset cfg_err", |cfg_err, 1'b0);
        set_cfg(0, 3, 4, 0, 1);
        for (int i = 0; i < 9; i++) tick(4'b0001, '0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < RD; i++) tick(4'b0001, '0);
        idle(4);

        // Single pulse on ch0, D=3 W=4 R=1
        set_cfg(0, 3, 4, 0, 1);
        tick(4'b0001, '0);
        idle(12);

        // Train on ch1, D=0 W=2 G=3 R=3
        set_cfg(1, 0, 2, 3, 3);
        tick(4'b0010, '0);
        idle(16);

        // Continuous toggle on ch2, then stop
        set_cfg(2, 0, 1, 0, 0);
        tick(4'b0100, '0);
        idle(7);
        tick('0, 4'b0100);
        idle(4);

        // W=0 rejected with cfg_err
        set_cfg(3, 2, 0, 1, 2);
        tick(4'b1000, '0);
        idle(3);

        // Start held while busy is ignored
        set_cfg(0, 2, 3, 1, 2);
        for (int i = 0; i < 5; i++) tick(4'b0001, '0);
        idle(10);

        // Start and stop together from IDLE: not started
        set_cfg(1, 1, 2, 1, 1);
        tick(4'b0010, 4'b0010);
        idle(6);

        // Simultaneous starts on all channels
        set_cfg(0, 0, 1, 0, 2); set_cfg(1, 1, 2, 2, 1); set_cfg(2, 4, 3, 0, 3); set_cfg(3, 2, 1, 4, 2);
        tick(4'hF, '0);
        idle(22);

        // Randomised traffic with config changing every cycle
        for (int i = 0; i < 400; i++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                set_cfg(ch, $urandom_range(0, 6), $urandom_range(0, 5),
                        $urandom_range(0, 4), $urandom_range(0, 4));
                st[ch] = ($urandom_range(0, 3) == 0);
                sp[ch] = ($urandom_range(0, 29) == 0);
            end
            tick(st, sp);
        end
        tick('0, 4'hF);
        idle(6);

        // Asynchronous reset during an active pulse
        set_cfg(0, 0, 40, 0, 1);
        tick(4'b0001, '0);
        idle(6);
        @(negedge clk);
        check_bit("pre-reset pulse ch0", pulse_out[0], 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_bit("async reset pulse_out", |pulse_out, 1'b0);
        check_bit("async reset ready", ready, 1'b0);
        check_bit("async reset busy", |busy, 1'b0);
        for (int ch = 0; ch < NCH; ch++) begin
            exp_q[ch].delete();
            b_start[ch] = 0;
            b_end[ch]   = 0;
        end
        idle(3);
        @(negedge clk);
        reset_n = 1'b1;
        set_cfg(0, 1, 2, 0, 1);
        for (int i = 0; i < RD + 1; i++) tick(4'b0001, '0);
        idle(8);

        for (int ch = 0; ch < NCH; ch++) begin
            checks++;
            if (exp_q[ch].size() != 0) begin
                errors++;
                $display("FAIL drain ch%0d: %0d events outstanding, expected 0", ch, exp_q[ch].size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
